// File: rtl/multicycle_seq.sv
// Moore sequencer for the 16-bit multicycle datapath; strobes decode from the state register (op_code used in EXEC_R/WB).
// Optional cycle/retire counters are built when MULTICYCLE_SEQ_PERF_EN is defined.
`timescale 1ns/1ps
module multicycle_seq #(
  parameter logic [3:0] ALU_ADD = 4'd0,
  parameter logic [3:0] ALU_SUB = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_code,
  input  logic        zero,
  input  logic        stall,
  output logic        EscCondCP,
  output logic        EscCP,
  output logic [3:0]  ULA_OP,
  output logic        ULA_A,
  output logic [1:0]  ULA_B,
  output logic        EscIR,
  output logic [1:0]  FonteCP,
  output logic        EscReg,
  output logic        r_w,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MULTICYCLE_SEQ_PERF_EN
  ,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ret_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    WB     = 3'd3,
    BRANCH = 3'd4,
    JUMP   = 3'd5,
    HALT   = 3'd6
  } state_e;

  state_e state_q, state_d, st;
  logic   illegal_q, illegal_d;
  logic   retire;

  // The branch condition is applied by the datapath, so zero is never sampled here.
  logic zero_unused;
  assign zero_unused = zero;

`ifdef MULTICYCLE_SEQ_PERF_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;
`else
  logic retire_unused;
  assign retire_unused = retire;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    if (!stall) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          if (op_code <= 4'h8) begin
            state_d = EXEC_R;
          end else begin
            case (op_code)
              4'hE:    state_d = BRANCH;
              4'hF:    state_d = JUMP;
              4'hC:    state_d = HALT;
              default: begin
                state_d = FETCH;
                retire  = 1'b1;
                if (op_code != 4'hD) illegal_d = 1'b1;
              end
            endcase
          end
        end
        EXEC_R:           state_d = WB;
        WB, BRANCH, JUMP: begin
          state_d = FETCH;
          retire  = 1'b1;
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_SEQ_PERF_EN
  always_comb begin
    cyc_cnt_d = (state_q != HALT) ? cyc_cnt_q + 16'd1 : cyc_cnt_q;
    ret_cnt_d = retire ? ret_cnt_q + 16'd1 : ret_cnt_q;
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
`ifdef MULTICYCLE_SEQ_PERF_EN
      cyc_cnt_q <= 16'd0;
      ret_cnt_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
`ifdef MULTICYCLE_SEQ_PERF_EN
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
`endif
    end
  end

  // Reset shows FETCH decode immediately, even before the first clock edge.
  always_comb begin
    st        = rst ? FETCH : state_q;
    EscCondCP = 1'b0;
    EscCP     = 1'b0;
    ULA_OP    = ALU_ADD;
    ULA_A     = 1'b0;
    ULA_B     = 2'd0;
    EscIR     = 1'b0;
    FonteCP   = 2'd0;
    EscReg    = 1'b0;
    r_w       = 1'b0;
    halted    = 1'b0;
    case (st)
      FETCH: begin
        EscIR = 1'b1;
        EscCP = 1'b1;
        ULA_B = 2'd1;
      end
      DECODE: ULA_B = 2'd2;
      EXEC_R, WB: begin
        ULA_A = 1'b1;
        if (op_code[3]) ULA_B = 2'd2;
        else            ULA_OP = op_code;
        if (st == WB) begin
          EscReg = 1'b1;
          r_w    = 1'b1;
        end
      end
      BRANCH: begin
        ULA_A     = 1'b1;
        ULA_OP    = ALU_SUB;
        EscCondCP = 1'b1;
        FonteCP   = 2'd1;
      end
      JUMP: begin
        EscCP   = 1'b1;
        FonteCP = 2'd2;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    if (stall && !rst) begin
      EscCP     = 1'b0;
      EscCondCP = 1'b0;
      EscIR     = 1'b0;
      EscReg    = 1'b0;
      r_w       = 1'b0;
    end
  end

  assign state   = st;
  assign illegal = illegal_q & ~rst;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: directed vector table, hand sequences (halt, perf counters) and
// randomized instruction streams against an instruction-path reference model.
`timescale 1ns/1ps
module tb_multicycle_seq;

  logic       clk = 1'b0;
  logic       rst, zero, stall;
  logic [3:0] op_code;
  logic       EscCondCP, EscCP, ULA_A, EscIR, EscReg, r_w, halted, illegal;
  logic [3:0] ULA_OP;
  logic [1:0] ULA_B, FonteCP;
  logic [2:0] state;
`ifdef MULTICYCLE_SEQ_PERF_EN
  logic [15:0] cyc_cnt, ret_cnt;
`endif

  multicycle_seq dut (
    .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .stall(stall),
    .EscCondCP(EscCondCP), .EscCP(EscCP), .ULA_OP(ULA_OP), .ULA_A(ULA_A), .ULA_B(ULA_B),
    .EscIR(EscIR), .FonteCP(FonteCP), .EscReg(EscReg), .r_w(r_w), .halted(halted),
    .illegal(illegal), .state(state)
`ifdef MULTICYCLE_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ccp, cp;
    logic [3:0] uop;
    logic       ua;
    logic [1:0] ub;
    logic       ir;
    logic [1:0] fcp;
    logic       er, rw, hlt, ill;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    logic       r, s, z;
    logic [3:0] op;
    outs_t      e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: each instruction is a list of visited states; k indexes it.
  int   path[$];
  int   k, mst, halt_cnt;
  logic mill;
  int   mcyc, mret;
  logic [3:0] cur_op;
  logic       r_i, s_i;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic outs_t mk(input int st, ir, cp, ccp, fcp, uop, ua, ub, er, rw, h, il);
    outs_t o;
    o.st = 3'(st); o.ir = 1'(ir); o.cp = 1'(cp); o.ccp = 1'(ccp); o.fcp = 2'(fcp);
    o.uop = 4'(uop); o.ua = 1'(ua); o.ub = 2'(ub); o.er = 1'(er); o.rw = 1'(rw);
    o.hlt = 1'(h); o.ill = 1'(il);
    return o;
  endfunction

  function automatic vec_t v(input logic r, s, z, input logic [3:0] op, input outs_t e);
    vec_t x;
    x.r = r; x.s = s; x.z = z; x.op = op; x.e = e;
    return x;
  endfunction

  function automatic outs_t exp_out(input int s, input logic [3:0] op, input logic stl, input logic ill);
    outs_t o;
    o = '0;
    o.st = 3'(s);
    o.ill = ill;
    case (s)
      0: begin o.ir = 1; o.cp = 1; o.ub = 2'd1; end
      1: o.ub = 2'd2;
      2, 3: begin
        o.ua = 1;
        if (op == 4'h8) o.ub = 2'd2;
        else            o.uop = op;
        if (s == 3) begin o.er = 1; o.rw = 1; end
      end
      4: begin o.ua = 1; o.uop = 4'd1; o.ccp = 1; o.fcp = 2'd1; end
      5: begin o.cp = 1; o.fcp = 2'd2; end
      6: o.hlt = 1;
      default: ;
    endcase
    if (stl) begin o.cp = 0; o.ccp = 0; o.ir = 0; o.er = 0; o.rw = 0; end
    return o;
  endfunction

  task automatic model_step(input logic r, s, input logic [3:0] op);
    if (r) begin
      k = 0; mst = 0; mill = 0; mcyc = 0; mret = 0;
    end else if (mst != 6) begin
      mcyc++;
      if (!s) begin
        if (k == 1) begin
          case (op)
            4'hE: path = '{0, 1, 4};
            4'hF: path = '{0, 1, 5};
            4'hC: path = '{0, 1, 6};
            4'h9, 4'hA, 4'hB, 4'hD: path = '{0, 1};
            default: path = '{0, 1, 2, 3};
          endcase
          if (op inside {[4'h9:4'hB]}) mill = 1;
        end
        k++;
        if (k >= path.size()) begin
          k = 0;
          mret++;
        end
        mst = path[k];
      end
    end
  endtask

  // Apply one cycle of inputs, compare against model (and table entry if given), then clock.
  task automatic cyc(input logic r, s, z, input logic [3:0] op, input bit has_exp,
                     input outs_t e, input string nm);
    outs_t act, mexp;
    rst = r; stall = s; zero = z; op_code = op;
    #1;
    act = {EscCondCP, EscCP, ULA_OP, ULA_A, ULA_B, EscIR, FonteCP, EscReg, r_w, halted, illegal, state};
    mexp = exp_out(r ? 0 : mst, op, s && !r, r ? 1'b0 : mill);
    chk({nm, "/model"}, 32'(act), 32'(mexp));
    if (has_exp) chk(nm, 32'(act), 32'(e));
`ifdef MULTICYCLE_SEQ_PERF_EN
    if (!r) begin
      chk({nm, "/cyc_cnt"}, 32'(cyc_cnt), 32'(mcyc[15:0]));
      chk({nm, "/ret_cnt"}, 32'(ret_cnt), 32'(mret[15:0]));
    end
`endif
    @(posedge clk);
    model_step(r, s, op);
    #1;
  endtask

  initial begin
    outs_t F0, F1, D0, D1, EXA, WBA, BR, JP, EXI, WBI, EX3, WB3S, WB3, H1;
    path = '{0, 1};
    k = 0; mst = 0; mill = 0; mcyc = 0; mret = 0; halt_cnt = 0; cur_op = 4'h0;
    rst = 1; stall = 0; zero = 0; op_code = 4'h0;

    //        st ir cp ccp fcp uop ua ub er rw h il
    F0   = mk(0, 1, 1, 0,  0,  0,  0, 1, 0, 0, 0, 0);
    F1   = mk(0, 1, 1, 0,  0,  0,  0, 1, 0, 0, 0, 1);
    D0   = mk(1, 0, 0, 0,  0,  0,  0, 2, 0, 0, 0, 0);
    D1   = mk(1, 0, 0, 0,  0,  0,  0, 2, 0, 0, 0, 1);
    EXA  = mk(2, 0, 0, 0,  0,  0,  1, 0, 0, 0, 0, 0);
    WBA  = mk(3, 0, 0, 0,  0,  0,  1, 0, 1, 1, 0, 0);
    BR   = mk(4, 0, 0, 1,  1,  1,  1, 0, 0, 0, 0, 0);
    JP   = mk(5, 0, 1, 0,  2,  0,  0, 0, 0, 0, 0, 0);
    EXI  = mk(2, 0, 0, 0,  0,  0,  1, 2, 0, 0, 0, 0);
    WBI  = mk(3, 0, 0, 0,  0,  0,  1, 2, 1, 1, 0, 0);
    EX3  = mk(2, 0, 0, 0,  0,  3,  1, 0, 0, 0, 0, 0);
    WB3S = mk(3, 0, 0, 0,  0,  3,  1, 0, 0, 0, 0, 0);
    WB3  = mk(3, 0, 0, 0,  0,  3,  1, 0, 1, 1, 0, 0);
    H1   = mk(6, 0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 1);

    tv.push_back(v(1, 0, 0, 4'h0, F0));  tv.push_back(v(1, 0, 0, 4'h0, F0));
    tv.push_back(v(0, 0, 0, 4'h0, F0));  tv.push_back(v(0, 0, 0, 4'h0, D0));
    tv.push_back(v(0, 0, 0, 4'h0, EXA)); tv.push_back(v(0, 0, 0, 4'h0, WBA));
    tv.push_back(v(0, 0, 1, 4'hE, F0));  tv.push_back(v(0, 0, 1, 4'hE, D0));
    tv.push_back(v(0, 0, 1, 4'hE, BR));
    tv.push_back(v(0, 0, 0, 4'hE, F0));  tv.push_back(v(0, 0, 0, 4'hE, D0));
    tv.push_back(v(0, 0, 0, 4'hE, BR));
    tv.push_back(v(0, 0, 0, 4'hF, F0));  tv.push_back(v(0, 0, 0, 4'hF, D0));
    tv.push_back(v(0, 0, 0, 4'hF, JP));
    tv.push_back(v(0, 0, 0, 4'h8, F0));  tv.push_back(v(0, 0, 0, 4'h8, D0));
    tv.push_back(v(0, 0, 0, 4'h8, EXI)); tv.push_back(v(0, 0, 0, 4'h8, WBI));
    tv.push_back(v(0, 0, 0, 4'h3, F0));  tv.push_back(v(0, 0, 0, 4'h3, D0));
    tv.push_back(v(0, 0, 0, 4'h3, EX3));
    tv.push_back(v(0, 1, 0, 4'h3, WB3S)); tv.push_back(v(0, 1, 0, 4'h3, WB3S));
    tv.push_back(v(0, 1, 0, 4'h3, WB3S)); tv.push_back(v(0, 0, 0, 4'h3, WB3));
    tv.push_back(v(0, 0, 0, 4'hA, F0));  tv.push_back(v(0, 0, 0, 4'hA, D0));
    tv.push_back(v(0, 0, 0, 4'hD, F1));  tv.push_back(v(0, 0, 0, 4'hD, D1));
    tv.push_back(v(0, 0, 0, 4'hC, F1));  tv.push_back(v(0, 0, 0, 4'hC, D1));
    tv.push_back(v(0, 0, 0, 4'hC, H1));  tv.push_back(v(0, 1, 0, 4'hC, H1));
    tv.push_back(v(0, 0, 0, 4'hC, H1));
    tv.push_back(v(1, 0, 0, 4'h0, F0));  tv.push_back(v(0, 0, 0, 4'h0, F0));

    for (int i = 0; i < tv.size(); i++)
      cyc(tv[i].r, tv[i].s, tv[i].z, tv[i].op, 1'b1, tv[i].e, $sformatf("vec%0d", i));

    // HALT must hold indefinitely, stall or not.
    cyc(1, 0, 0, 4'hC, 1'b0, '0, "halt_rst");
    cyc(0, 0, 0, 4'hC, 1'b0, '0, "halt_f");
    cyc(0, 0, 0, 4'hC, 1'b0, '0, "halt_d");
    for (int i = 0; i < 20; i++)
      cyc(0, 1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)), 1'b0, '0, "halt_hold");
    chk("halt_sticky", 32'({halted, state}), 32'({1'b1, 3'd6}));

`ifdef MULTICYCLE_SEQ_PERF_EN
    cyc(1, 0, 0, 4'h0, 1'b0, '0, "perf_rst");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 4'h0, 1'b0, '0, "perf_add");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'hE, 1'b0, '0, "perf_beq");
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 4'hD, 1'b0, '0, "perf_nop");
    rst = 0; stall = 0; #1;
    chk("perf_cyc9", 32'(cyc_cnt), 32'd9);
    chk("perf_ret3", 32'(ret_cnt), 32'd3);
    cyc(0, 0, 0, 4'h0, 1'b0, '0, "perf_f");
    cyc(0, 0, 0, 4'h0, 1'b0, '0, "perf_d");
    cyc(1, 0, 0, 4'h0, 1'b0, '0, "perf_mid_rst");
    rst = 0; #1;
    chk("perf_rst_state", 32'(state), 32'd0);
    chk("perf_rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("perf_rst_ret", 32'(ret_cnt), 32'd0);
`endif

    cyc(1, 0, 0, 4'h0, 1'b0, '0, "rand_rst");
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mst == 6) begin
        halt_cnt++;
        r_i = (halt_cnt > 3);
      end else begin
        r_i = ($urandom_range(0, 199) == 0);
      end
      if (k == 0) begin
        cur_op = 4'($urandom_range(0, 15));
        if (cur_op == 4'hC && $urandom_range(0, 3) != 0) cur_op = 4'hD;
      end
      s_i = ($urandom_range(0, 3) == 0);
      cyc(r_i, s_i, 1'($urandom_range(0, 1)), cur_op, 1'b0, '0, "rand");
      if (r_i) halt_cnt = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
